imem_refill_ctrl: RTL
=====================

# imem_refill_ctrl

Instruction-fetch refill controller between the CPU fetch port (word-address PC, hit/stall) and the DDR2-backed memory read port. It holds a small direct-mapped instruction line buffer and answers CPU fetches from it. On a miss it sequences word-by-word refills from DDR2 and raises `fetch_hit` only when the requested word is valid. It runs entirely on `clk_in`; the CPU runs on the slower divided clock and stalls on `~fetch_hit`.

## Interface
- `ADDR_W`, 8, word-address width of the fetch and memory ports
- `DATA_W`, 32, instruction word width
- `LINE_WORDS`, 4, words per line (power of two, ≥2)
- `LINES`, 16, number of lines (power of two)
- `clk_in`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `mem_ready`  in  1  level; backing store loaded from SD into DDR2
- `fetch_addr`  in  ADDR_W  CPU word address (PC>>2); held stable by the CPU while `fetch_hit`=0
- `fetch_hit`  out  1  requested word valid this cycle
- `fetch_data`  out  DATA_W  instruction word; meaningful only when `fetch_hit`=1
- `mem_req`  out  1  read request to DDR2 port
- `mem_addr`  out  ADDR_W  word address of the request
- `mem_ack`  in  1  one-cycle pulse; `mem_rdata` valid in the same cycle
- `mem_rdata`  in  DATA_W  read data
- `refill_count`  out  16  number of refills started (see Configuration)

## Operation
- Address split: offset = low log2(LINE_WORDS) bits; index = next log2(LINES) bits; tag = remaining bits. Defaults give 2/4/2.
- States: `WAIT_INIT`, `LOOKUP`, `REQ`, `WAIT_ACK`, `COMMIT`.
- `WAIT_INIT`: all outputs 0. Go to `LOOKUP` on the first cycle with `mem_ready`=1.
- `LOOKUP`: `fetch_hit` = valid[index] && tag[index]==tag(fetch_addr), combinational from the current `fetch_addr`. `fetch_data` = data[index][offset].
  - On a miss, latch line base = {tag,index,0}, clear valid[index], set word counter w=0, go to `REQ`.
- `REQ`: drive `mem_req`=1 with `mem_addr`=base+w, go to `WAIT_ACK`.
- `WAIT_ACK`: hold `mem_req` and `mem_addr` stable until `mem_ack`.
  - On ack, write data[index][w]=mem_rdata and drop `mem_req` the next cycle.
  - If w==LINE_WORDS-1, go to `COMMIT`; otherwise w+1 and go to `REQ`.
- `COMMIT`: write tag[index] and set valid[index]; go to `LOOKUP`.
- Words are fetched in ascending order from offset 0; there is no critical-word-first.
- `fetch_hit` is 0 in every state except `LOOKUP`.
- A `fetch_addr` change during refill is ignored until `LOOKUP`; the latched line always completes.
- `mem_ack` outside `WAIT_ACK` is ignored.
- `mem_ready` falling after init has no effect; the contents are assumed static.
- A refill whose index equals a valid line replaces that line; there is no write-back, since the path is read-only.

## Timing
- Reset values: state `WAIT_INIT`; all valid bits 0; `fetch_hit`, `fetch_data`, `mem_req`, `mem_addr`, `refill_count` = 0.
- Hit latency: 0 cycles, combinational in `LOOKUP`.
- Miss penalty with ack latency L cycles after `mem_req` rises: 1 (LOOKUP) + LINE_WORDS·(L+1) + 1 (COMMIT) cycles until `fetch_hit`=1.
- `mem_req` is low for at least one cycle between consecutive requests.
- Reset mid-refill aborts immediately. The line being filled stays invalid, and no partial tag is written.
- Reset asserted in the same cycle as `mem_ack`: reset wins and the data is discarded.

## Configuration
- `ICACHE_STATS_EN` defined: `refill_count` increments by 1 on each `LOOKUP`→`REQ` miss transition and saturates at 0xFFFF.
- `ICACHE_STATS_EN` undefined: the counter register is not built, and `refill_count` is tied to 0. The port is always present.

## Structure
- Shared package `imem_pkg`:
  - state enum
  - derived widths OFF_W, IDX_W, TAG_W from the parameters
  - line-base helper function
- One sub-module, `icache_line_ram`, holds the valid, tag and data arrays. It has:
  - an asynchronous read port indexed by index/offset
  - a synchronous word write
  - a synchronous tag/valid write
  - an invalidate-one port
  - an asynchronous clear of the valid bits on reset
- The FSM and counter live in `imem_refill_ctrl`.

## Test plan
- Reset, `mem_ready`=0, `fetch_addr`=0x00 for 100 cycles -> `fetch_hit`=0 and `mem_req`=0 throughout.
- `mem_ready`=1, `fetch_addr`=0x05, memory returns 0xA000_0000+addr with L=3 -> requests appear for 0x04, 0x05, 0x06, 0x07 in order. `fetch_hit`=1 with `fetch_data`=0xA000_0005 exactly 1+4·4+1=18 cycles after the first `LOOKUP`.
- Then `fetch_addr`=0x06 -> `fetch_hit`=1 with 0xA000_0006 in the same cycle, and no `mem_req`.
- `fetch_addr`=0x45 (same index, tag 1) -> refill of 0x44..0x47 and data 0xA000_0045. Returning to 0x05 misses and refills 0x04..0x07 again.
- Assert `reset` on the cycle after the 2nd ack of a refill of 0x08 -> all outputs 0 at once. After release and `mem_ready`, the refill restarts at 0x08, and 0x09..0x0B are all requested.
- With `ICACHE_STATS_EN`, after the scenario sequence 2–4 -> `refill_count`=3. Without the macro -> `refill_count`=0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and width helpers for the instruction-fetch refill controller.
// Optional statistics counter is enabled by defining ICACHE_STATS_EN.
package imem_pkg;

    typedef enum logic [2:0] {
        S_WAIT_INIT = 3'd0,
        S_LOOKUP    = 3'd1,
        S_REQ       = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_COMMIT    = 3'd4
    } state_t;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_LINES      = 16;

    function automatic int off_width(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int addr_w, input int line_words, input int lines);
        return addr_w - $clog2(line_words) - $clog2(lines);
    endfunction

    // Clears the offset bits so the result addresses word 0 of the line.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int off_w);
        return (addr >> off_w) << off_w;
    endfunction

endpackage

// File: rtl/imem_refill_ctrl_line_ram.sv
// Direct-mapped instruction line storage: valid bits, tags and data words.
// Asynchronous read port; valid bits clear asynchronously on reset.
module icache_line_ram
    import imem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LINES      = DEF_LINES
) (
    input  logic                                            clk_in,
    input  logic                                            reset,
    input  logic [idx_width(LINES)-1:0]                     rd_idx,
    input  logic [off_width(LINE_WORDS)-1:0]                rd_off,
    output logic                                            rd_valid,
    output logic [tag_width(ADDR_W, LINE_WORDS, LINES)-1:0] rd_tag,
    output logic [DATA_W-1:0]                               rd_data,
    input  logic                                            wr_en,
    input  logic [idx_width(LINES)-1:0]                     wr_idx,
    input  logic [off_width(LINE_WORDS)-1:0]                wr_off,
    input  logic [DATA_W-1:0]                               wr_data,
    input  logic                                            commit_en,
    input  logic [idx_width(LINES)-1:0]                     commit_idx,
    input  logic [tag_width(ADDR_W, LINE_WORDS, LINES)-1:0] commit_tag,
    input  logic                                            inv_en,
    input  logic [idx_width(LINES)-1:0]                     inv_idx
);

    localparam int TAG_W = tag_width(ADDR_W, LINE_WORDS, LINES);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES][LINE_WORDS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx][rd_off];

    always_comb begin
        valid_d = valid_q;
        if (commit_en) valid_d[commit_idx] = 1'b1;
        if (inv_en)    valid_d[inv_idx]    = 1'b0;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // Tag and data contents are only meaningful behind a set valid bit, so no reset.
    always_ff @(posedge clk_in) begin
        if (commit_en) tag_mem[commit_idx] <= commit_tag;
        if (wr_en)     data_mem[wr_idx][wr_off] <= wr_data;
    end

endmodule

// File: rtl/imem_refill_ctrl.sv
// Instruction-fetch refill controller: answers CPU fetches from the line buffer
// and refills missing lines word by word from DDR2. Macro: ICACHE_STATS_EN.
module imem_refill_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LINES      = DEF_LINES
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              mem_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_hit,
    output logic [DATA_W-1:0] fetch_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       refill_count
);

    localparam int OFF_W = off_width(LINE_WORDS);
    localparam int IDX_W = idx_width(LINES);
    localparam int TAG_W = tag_width(ADDR_W, LINE_WORDS, LINES);
    localparam logic [OFF_W-1:0] LAST_W = OFF_W'(LINE_WORDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [OFF_W-1:0]  w_q, w_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic [OFF_W-1:0]  f_off;
    logic [IDX_W-1:0]  f_idx;
    logic [TAG_W-1:0]  f_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit_raw;
    logic              wr_en, commit_en, inv_en;

    assign f_off    = fetch_addr[OFF_W-1:0];
    assign f_idx    = fetch_addr[OFF_W +: IDX_W];
    assign f_tag    = fetch_addr[ADDR_W-1 -: TAG_W];
    assign fill_idx = base_q[OFF_W +: IDX_W];
    assign fill_tag = base_q[ADDR_W-1 -: TAG_W];

    icache_line_ram #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS),
        .LINES      (LINES)
    ) u_line_ram (
        .clk_in     (clk_in),
        .reset      (reset),
        .rd_idx     (f_idx),
        .rd_off     (f_off),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_idx     (fill_idx),
        .wr_off     (w_q),
        .wr_data    (mem_rdata),
        .commit_en  (commit_en),
        .commit_idx (fill_idx),
        .commit_tag (fill_tag),
        .inv_en     (inv_en),
        .inv_idx    (f_idx)
    );

    // Hit is combinational so a resident word costs the stalled CPU no cycles.
    assign hit_raw    = rd_valid && (rd_tag == f_tag);
    assign fetch_hit  = (state_q == S_LOOKUP) && hit_raw;
    assign fetch_data = fetch_hit ? rd_data : '0;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        w_d        = w_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        wr_en      = 1'b0;
        commit_en  = 1'b0;
        inv_en     = 1'b0;
        case (state_q)
            S_WAIT_INIT: begin
                if (mem_ready) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (!hit_raw) begin
                    base_d  = ADDR_W'(line_base(32'(fetch_addr), OFF_W));
                    w_d     = '0;
                    inv_en  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // REQ is also the mandatory idle gap between two requests.
                mem_req_d  = 1'b1;
                mem_addr_d = base_q | ADDR_W'(w_q);
                state_d    = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (mem_ack) begin
                    wr_en     = 1'b1;
                    mem_req_d = 1'b0;
                    if (w_q == LAST_W) begin
                        state_d = S_COMMIT;
                    end else begin
                        w_d     = w_q + OFF_W'(1);
                        state_d = S_REQ;
                    end
                end
            end
            S_COMMIT: begin
                commit_en = 1'b1;
                state_d   = S_LOOKUP;
            end
            default: state_d = S_WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= S_WAIT_INIT;
            base_q     <= '0;
            w_q        <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            w_q        <= w_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] refill_count_q, refill_count_d;
    logic        refill_start;

    assign refill_start = (state_q == S_LOOKUP) && !hit_raw;

    always_comb begin
        refill_count_d = refill_count_q;
        if (refill_start && (refill_count_q != 16'hFFFF))
            refill_count_d = refill_count_q + 16'd1;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) refill_count_q <= '0;
        else       refill_count_q <= refill_count_d;
    end

    assign refill_count = refill_count_q;
`else
    assign refill_count = 16'h0000;
`endif

endmodule
